sa_wdata_channel: RTL and testbench
===================================

# sa_wdata_channel

Slave-side write-data (W) channel of the AXI4 interconnect: receives the broadcast W beats from all master-side W dispatchers and forwards exactly one master's burst at a time to its slave port. Burst order is taken from an internal order FIFO loaded by the AW arbitration each time it grants an AW transfer to this slave, so W bursts reach the slave in AW order. One instance sits per slave port, between the per-master W dispatchers and the slave.

## Interface
- MST_AMT, 2, number of masters (dispatchers) feeding this slave
- DATA_WIDTH, 32, W data width
- MST_ID_W, $clog2(MST_AMT), master index width
- ORDER_DEPTH, 4, outstanding AW grants whose W bursts are pending (power of 2, ≥2)

- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- dsp_WDATA_i  in  DATA_WIDTH*MST_AMT  W data per master, master m at [DATA_WIDTH*(m+1)-1 -: DATA_WIDTH]
- dsp_WLAST_i  in  MST_AMT  WLAST per master
- dsp_WVALID_i  in  MST_AMT  WVALID per master
- dsp_WDATA_sel_i  in  MST_AMT  master m's current burst targets this slave
- dsp_WREADY_o  out  MST_AMT  WREADY per master
- aw_grant_mst_id_i  in  MST_ID_W  master granted on this slave's AW channel
- aw_grant_valid_i  in  1  grant strobe, one cycle per accepted AW transfer
- aw_grant_ready_o  out  1  order FIFO can accept a grant
- s_WDATA_o  out  DATA_WIDTH  to slave
- s_WLAST_o  out  1  to slave
- s_WVALID_o  out  1  to slave
- s_WREADY_i  in  1  from slave

## Operation
- Order FIFO: push aw_grant_mst_id_i when aw_grant_valid_i & aw_grant_ready_o; aw_grant_ready_o = !full. Grant while full is a protocol error, dropped.
- FSM: IDLE (FIFO empty) / FWD (head = current master h). IDLE→FWD on FIFO non-empty. FWD: pop on accepted beat of h with WLAST; stay FWD with new head if FIFO still non-empty (no bubble), else →IDLE.
- In FWD, eligible = dsp_WVALID_i[h] & dsp_WDATA_sel_i[h]. s_WVALID_o = eligible; s_WDATA_o/s_WLAST_o = master h's lanes.
- dsp_WREADY_o[h] = s_WREADY_i & dsp_WDATA_sel_i[h] in FWD; all other bits 0. IDLE: all 0.
- Masters with sel low or not at head are never acknowledged; their data is never forwarded.
- h ≥ MST_AMT (non-power-of-2 MST_AMT): treated as never eligible.
- Beat count per burst not checked; burst end is WLAST only.

## Timing
- Reset (async assert, sync deassert to ACLK): FIFO empty, FSM IDLE; dsp_WREADY_o=0, s_WVALID_o=0, s_WLAST_o=0, s_WDATA_o=0, aw_grant_ready_o=1.
- Grant pushed at edge N → head valid, forwarding possible in cycle N+1.
- Without output register: dsp→slave combinational, 0-cycle latency; s_WREADY_i→dsp_WREADY_o combinational.
- Last beat and next burst's first beat may be accepted on consecutive cycles.
- Push and pop in same cycle: both take effect; count unchanged.
- Full: aw_grant_ready_o=0 until first pop; deasserts same cycle count reaches ORDER_DEPTH.
- Reset mid-burst: burst state discarded; outputs return to reset values immediately.

## Configuration
- SA_WDATA_OUT_REG_EN defined: 2-entry skid buffer on slave side; s_WDATA_o/s_WLAST_o/s_WVALID_o registered, 1-cycle latency; dsp_WREADY_o[h] = skid not full (no combinational path from s_WREADY_i); pop on upstream WLAST acceptance into skid. Full throughput kept. Skid empty on reset.
- Undefined: purely combinational forwarding as above.

## Structure
- Shared interconnect package/header: FSM state encodings (IDLE, FWD), master-index width function.
- One sub-module: sa_wdata_order_fifo (synchronous FIFO, MST_ID_W × ORDER_DEPTH, full/empty, async active-low reset).
- Skid buffer inline under the macro.

## Test plan
- Grant m0, m0 sends 4 beats 0xA0..0xA3, WLAST on 4th, s_WREADY_i=1 → slave sees 4 beats in order, WLAST on 4th, FSM IDLE after.
- Grants m1 then m0, both valid from start → m0 WREADY=0 until m1 WLAST; m0 first beat accepted next cycle, no bubble.
- s_WREADY_i pattern 1,0,1,0 over 4-beat burst → 4 beats delivered, none lost/duplicated, WREADY mirrors s_WREADY_i (combinational build).
- 4 grants, no W data → aw_grant_ready_o=0 after 4th; 5th held; one burst completes → ready=1 next cycle.
- Head m0 with sel=0, m1 valid with sel=1 but not granted → s_WVALID_o=0, dsp_WREADY_o=2'b00.
- Reset asserted after 2 of 4 beats → all outputs to reset values, aw_grant_ready_o=1, new grant then burst forwards normally.

Source files
------------

// File: rtl/sa_wdata_pkg.sv
// Shared definitions for the slave-side W channel: FSM state encoding and
// the master-index width helper.
package sa_wdata_pkg;

  // IDLE: no AW grant is waiting for its W burst. FWD: the order FIFO head
  // names the master whose burst is being forwarded.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } state_e;

  // Width needed to index mst_amt masters; never less than one bit.
  function automatic int mst_id_width(input int mst_amt);
    return (mst_amt > 1) ? $clog2(mst_amt) : 1;
  endfunction

endpackage

// File: rtl/sa_wdata_order_fifo.sv
// Order FIFO holding the master index of every AW grant whose W burst has
// not yet been fully forwarded. DEPTH must be a power of two.
module sa_wdata_order_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  // A push while full or a pop while empty is dropped.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage write.
  // NOTE: the storage array has no reset; the count gates every read, so
  // stale entries are never observed and the array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sa_wdata_channel.sv
// Slave-side AXI4 W channel: forwards one master's W burst at a time, in the
// order the AW arbiter granted this slave.
// Optional macro SA_WDATA_OUT_REG_EN: registers the slave-side outputs through
// a 2-entry skid buffer (1-cycle latency, full throughput).
module sa_wdata_channel
  import sa_wdata_pkg::*;
#(
  parameter int MST_AMT     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int MST_ID_W    = mst_id_width(MST_AMT),
  parameter int ORDER_DEPTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
  input  logic [MST_AMT-1:0]            dsp_WLAST_i,
  input  logic [MST_AMT-1:0]            dsp_WVALID_i,
  input  logic [MST_AMT-1:0]            dsp_WDATA_sel_i,
  output logic [MST_AMT-1:0]            dsp_WREADY_o,
  input  logic [MST_ID_W-1:0]           aw_grant_mst_id_i,
  input  logic                          aw_grant_valid_i,
  output logic                          aw_grant_ready_o,
  output logic [DATA_WIDTH-1:0]         s_WDATA_o,
  output logic                          s_WLAST_o,
  output logic                          s_WVALID_o,
  input  logic                          s_WREADY_i
);

  localparam int CNT_W = $clog2(ORDER_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [MST_ID_W-1:0]   head_id;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push_ok, pop, fwd, up_ready, eligible, up_accept;
  logic                  h_valid, h_sel, h_last;
  logic [DATA_WIDTH-1:0] h_data;

  assign push_ok          = aw_grant_valid_i & ~fifo_full;
  assign aw_grant_ready_o = ~fifo_full;

  sa_wdata_order_fifo #(
    .WIDTH (MST_ID_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk         (ACLK),
    .rst_n       (ARESETn),
    .push_i      (push_ok),
    .push_data_i (aw_grant_mst_id_i),
    .pop_i       (pop),
    .head_o      (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Select the lanes of the head master; an index with no master selects
  // nothing, so it is never eligible.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    h_valid = 1'b0;
    h_sel   = 1'b0;
    h_last  = 1'b0;
    h_data  = '0;
    for (int m = 0; m < MST_AMT; m++) begin
      if (head_id == MST_ID_W'(m)) begin
        h_valid = dsp_WVALID_i[m];
        h_sel   = dsp_WDATA_sel_i[m];
        h_last  = dsp_WLAST_i[m];
        h_data  = dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH];
      end
    end
  end

  assign fwd       = (state_q == ST_FWD);
  assign eligible  = fwd & h_valid & h_sel;
  assign up_accept = eligible & up_ready;
  assign pop       = up_accept & h_last;

  // Next state and per-master ready. The pending push is looked at so a grant
  // is forwardable the cycle after it is taken, and a pop with more grants
  // queued keeps FWD so back-to-back bursts have no bubble.
  always_comb begin
    state_d      = state_q;
    dsp_WREADY_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (push_ok || !fifo_empty) state_d = ST_FWD;
      end
      ST_FWD: begin
        for (int m = 0; m < MST_AMT; m++) begin
          if (head_id == MST_ID_W'(m)) dsp_WREADY_o[m] = up_ready & h_sel;
        end
        if (pop && (fifo_count == CNT_W'(1)) && !push_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

`ifdef SA_WDATA_OUT_REG_EN
  // Two-entry skid buffer: upstream ready depends only on occupancy, so there
  // is no combinational path from s_WREADY_i back to the masters.
  logic [DATA_WIDTH:0] skid0_q, skid1_q, in_beat;
  logic [1:0]          skid_cnt_q;
  logic                out_fire;

  assign up_ready   = (skid_cnt_q != 2'd2);
  assign out_fire   = (skid_cnt_q != 2'd0) & s_WREADY_i;
  assign in_beat    = {h_last, h_data};
  assign s_WVALID_o = (skid_cnt_q != 2'd0);
  assign s_WDATA_o  = skid0_q[DATA_WIDTH-1:0];
  assign s_WLAST_o  = skid0_q[DATA_WIDTH];

  // Skid occupancy and data; entry 0 always drives the slave.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      skid0_q    <= '0;
      skid1_q    <= '0;
      skid_cnt_q <= 2'd0;
    end else begin
      unique case (skid_cnt_q)
        2'd0: begin
          if (up_accept) begin
            skid0_q    <= in_beat;
            skid_cnt_q <= 2'd1;
          end
        end
        2'd1: begin
          if (up_accept && out_fire) begin
            skid0_q <= in_beat;
          end else if (out_fire) begin
            skid_cnt_q <= 2'd0;
          end else if (up_accept) begin
            skid1_q    <= in_beat;
            skid_cnt_q <= 2'd2;
          end
        end
        default: begin
          if (out_fire) begin
            skid0_q    <= skid1_q;
            skid_cnt_q <= 2'd1;
          end
        end
      endcase
    end
  end
`else
  // Purely combinational forwarding of the head master's lanes.
  assign up_ready   = s_WREADY_i;
  assign s_WVALID_o = eligible;
  assign s_WDATA_o  = fwd ? h_data : '0;
  assign s_WLAST_o  = fwd & h_last;
`endif

endmodule

// File: tb/tb_sa_wdata_channel.sv
// Self-checking bench for sa_wdata_channel (default combinational build).
// A queue-level model of AW order predicts the slave-side outputs every cycle;
// directed tests add literal expectations on top.
module tb_sa_wdata_channel;

  localparam int MST_AMT     = 2;
  localparam int DATA_WIDTH  = 32;
  localparam int MST_ID_W    = 1;
  localparam int ORDER_DEPTH = 4;

  logic                          ACLK;
  logic                          ARESETn;
  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i;
  logic [MST_AMT-1:0]            dsp_WLAST_i;
  logic [MST_AMT-1:0]            dsp_WVALID_i;
  logic [MST_AMT-1:0]            dsp_WDATA_sel_i;
  logic [MST_AMT-1:0]            dsp_WREADY_o;
  logic [MST_ID_W-1:0]           aw_grant_mst_id_i;
  logic                          aw_grant_valid_i;
  logic                          aw_grant_ready_o;
  logic [DATA_WIDTH-1:0]         s_WDATA_o;
  logic                          s_WLAST_o;
  logic                          s_WVALID_o;
  logic                          s_WREADY_i;

  int checks = 0;
  int errors = 0;

  int unsigned   mq[$];      // model: granted master ids in AW order
  logic [32:0]   got_q[$];   // {last, data} of every beat the slave accepted
  logic [32:0]   exp_q[$];

  sa_wdata_channel #(
    .MST_AMT     (MST_AMT),
    .DATA_WIDTH  (DATA_WIDTH),
    .MST_ID_W    (MST_ID_W),
    .ORDER_DEPTH (ORDER_DEPTH)
  ) dut (
    .ACLK              (ACLK),
    .ARESETn           (ARESETn),
    .dsp_WDATA_i       (dsp_WDATA_i),
    .dsp_WLAST_i       (dsp_WLAST_i),
    .dsp_WVALID_i      (dsp_WVALID_i),
    .dsp_WDATA_sel_i   (dsp_WDATA_sel_i),
    .dsp_WREADY_o      (dsp_WREADY_o),
    .aw_grant_mst_id_i (aw_grant_mst_id_i),
    .aw_grant_valid_i  (aw_grant_valid_i),
    .aw_grant_ready_o  (aw_grant_ready_o),
    .s_WDATA_o         (s_WDATA_o),
    .s_WLAST_o         (s_WLAST_o),
    .s_WVALID_o        (s_WVALID_o),
    .s_WREADY_i        (s_WREADY_i)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_lane(input int m, input logic [31:0] data, input logic last,
                          input logic valid, input logic sel);
    dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH] = data;
    dsp_WLAST_i[m]     = last;
    dsp_WVALID_i[m]    = valid;
    dsp_WDATA_sel_i[m] = sel;
  endtask

  task automatic grant(input int m);
    aw_grant_valid_i  = 1'b1;
    aw_grant_mst_id_i = MST_ID_W'(m);
    tick();
    aw_grant_valid_i  = 1'b0;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // Model of the order queue: a grant is taken while fewer than ORDER_DEPTH
  // are pending; the head is retired when its master's WLAST beat is taken.
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mq.delete();
    end else begin
      bit          retire;
      bit          room;
      int unsigned h;
      retire = 1'b0;
      room   = (mq.size() < ORDER_DEPTH);
      if (mq.size() > 0) begin
        h = mq[0];
        retire = dsp_WVALID_i[h] && dsp_WDATA_sel_i[h] && s_WREADY_i && dsp_WLAST_i[h];
      end
      if (retire) void'(mq.pop_front());
      if (aw_grant_valid_i && room) mq.push_back(int'(aw_grant_mst_id_i));
    end
  end

  // Per-cycle comparison against the model, mid-cycle where inputs are stable.
  always @(negedge ACLK) begin
    logic                  e_valid, e_last;
    logic [DATA_WIDTH-1:0] e_data;
    logic [MST_AMT-1:0]    e_wready;
    int unsigned           h;
    e_valid  = 1'b0;
    e_last   = 1'b0;
    e_data   = '0;
    e_wready = '0;
    if (mq.size() > 0) begin
      h = mq[0];
      e_valid     = dsp_WVALID_i[h] & dsp_WDATA_sel_i[h];
      e_last      = dsp_WLAST_i[h];
      e_data      = dsp_WDATA_i[DATA_WIDTH*h +: DATA_WIDTH];
      e_wready[h] = s_WREADY_i & dsp_WDATA_sel_i[h];
    end
    check("cyc_s_WVALID", 64'(s_WVALID_o), 64'(e_valid));
    check("cyc_s_WDATA", 64'(s_WDATA_o), 64'(e_data));
    check("cyc_s_WLAST", 64'(s_WLAST_o), 64'(e_last));
    check("cyc_dsp_WREADY", 64'(dsp_WREADY_o), 64'(e_wready));
    check("cyc_aw_ready", 64'(aw_grant_ready_o), 64'(mq.size() < ORDER_DEPTH));
    if (s_WVALID_o && s_WREADY_i) got_q.push_back({s_WLAST_o, s_WDATA_o});
  end

  initial begin
    int beat;
    logic acc;

    ARESETn           = 1'b0;
    dsp_WDATA_i       = '0;
    dsp_WLAST_i       = '0;
    dsp_WVALID_i      = '0;
    dsp_WDATA_sel_i   = '0;
    aw_grant_mst_id_i = '0;
    aw_grant_valid_i  = 1'b0;
    s_WREADY_i        = 1'b1;
    tick();
    tick();
    check("rst_s_WVALID", 64'(s_WVALID_o), 64'd0);
    check("rst_s_WDATA", 64'(s_WDATA_o), 64'd0);
    check("rst_dsp_WREADY", 64'(dsp_WREADY_o), 64'd0);
    check("rst_aw_ready", 64'(aw_grant_ready_o), 64'd1);
    ARESETn = 1'b1;
    tick();

    // Test 1: single 4-beat burst from m0.
    got_q.delete();
    grant(0);
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 32'hA0 + 32'(i), (i == 3), 1'b1, 1'b1);
      tick();
    end
    #1;
    check("t1_idle_no_valid", 64'(s_WVALID_o), 64'd0);
    check("t1_idle_no_ready", 64'(dsp_WREADY_o), 64'd0);
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_q = '{33'h0_000000A0, 33'h0_000000A1, 33'h0_000000A2, 33'h1_000000A3};
    check_log("t1");

    // Test 2: grants m1 then m0; m0 waits, then follows with no bubble.
    got_q.delete();
    grant(1);
    grant(0);
    set_lane(1, 32'hB0, 1'b0, 1'b1, 1'b1);
    set_lane(0, 32'hC0, 1'b0, 1'b1, 1'b1);
    #1;
    check("t2_m0_blocked_a", 64'(dsp_WREADY_o), 64'b10);
    tick();
    set_lane(1, 32'hB1, 1'b1, 1'b1, 1'b1);
    #1;
    check("t2_m0_blocked_b", 64'(dsp_WREADY_o), 64'b10);
    tick();
    set_lane(1, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t2_m0_now_ready", 64'(dsp_WREADY_o), 64'b01);
    check("t2_no_bubble_valid", 64'(s_WVALID_o), 64'd1);
    check("t2_no_bubble_data", 64'(s_WDATA_o), 64'hC0);
    tick();
    set_lane(0, 32'hC1, 1'b1, 1'b1, 1'b1);
    tick();
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_q = '{33'h0_000000B0, 33'h1_000000B1, 33'h0_000000C0, 33'h1_000000C1};
    check_log("t2");

    // Test 3: slave ready toggles 1,0,1,0...; ready mirrors it combinationally.
    got_q.delete();
    grant(0);
    beat = 0;
    for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
      set_lane(0, 32'hD0 + 32'(beat), (beat == 3), 1'b1, 1'b1);
      s_WREADY_i = (cyc % 2 == 0);
      #1;
      check("t3_wready_mirror", 64'(dsp_WREADY_o[0]), 64'(s_WREADY_i));
      acc = dsp_WREADY_o[0];
      tick();
      if (acc) beat++;
    end
    check("t3_all_beats_taken", 64'(beat), 64'd4);
    s_WREADY_i = 1'b1;
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_q = '{33'h0_000000D0, 33'h0_000000D1, 33'h0_000000D2, 33'h1_000000D3};
    check_log("t3");

    // Test 4: fill the order FIFO; fifth grant is held until one burst ends.
    aw_grant_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aw_grant_mst_id_i = MST_ID_W'(i % 2);
      tick();
      if (i == 2) check("t4_ready_after_3", 64'(aw_grant_ready_o), 64'd1);
    end
    check("t4_full_after_4", 64'(aw_grant_ready_o), 64'd0);
    aw_grant_mst_id_i = 1'b1;
    tick();
    tick();
    check("t4_fifth_held", 64'(aw_grant_ready_o), 64'd0);
    set_lane(0, 32'h55, 1'b1, 1'b1, 1'b1);
    #1;
    check("t4_head_m0", 64'(dsp_WREADY_o), 64'b01);
    tick();
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t4_ready_after_pop", 64'(aw_grant_ready_o), 64'd1);
    tick();
    aw_grant_valid_i = 1'b0;
    got_q.delete();
    set_lane(0, 32'h60, 1'b1, 1'b1, 1'b1);
    set_lane(1, 32'h61, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("t4_drained_valid", 64'(s_WVALID_o), 64'd0);
    check("t4_drained_ready", 64'(dsp_WREADY_o), 64'b00);
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_q = '{33'h1_00000061, 33'h1_00000060, 33'h1_00000061, 33'h1_00000061};
    check_log("t4_drain");

    // Test 5: head m0 not selected; m1 selected but not granted.
    grant(0);
    set_lane(0, 32'h77, 1'b1, 1'b1, 1'b0);
    set_lane(1, 32'h88, 1'b1, 1'b1, 1'b1);
    #1;
    check("t5_no_valid", 64'(s_WVALID_o), 64'd0);
    check("t5_no_ready", 64'(dsp_WREADY_o), 64'b00);
    tick();
    check("t5_still_no_valid", 64'(s_WVALID_o), 64'd0);

    // Test 6: reset after 2 of 4 beats, then a fresh burst.
    got_q.delete();
    set_lane(1, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      set_lane(0, 32'hE0 + 32'(i), 1'b0, 1'b1, 1'b1);
      tick();
    end
    set_lane(0, 32'hE2, 1'b0, 1'b1, 1'b1);
    #1;
    ARESETn = 1'b0;
    #1;
    check("t6_rst_valid", 64'(s_WVALID_o), 64'd0);
    check("t6_rst_data", 64'(s_WDATA_o), 64'd0);
    check("t6_rst_last", 64'(s_WLAST_o), 64'd0);
    check("t6_rst_wready", 64'(dsp_WREADY_o), 64'd0);
    check("t6_rst_aw_ready", 64'(aw_grant_ready_o), 64'd1);
    exp_q = '{33'h0_000000E0, 33'h0_000000E1};
    check_log("t6_pre_reset");
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    ARESETn = 1'b1;
    tick();
    got_q.delete();
    grant(1);
    set_lane(1, 32'hF0, 1'b0, 1'b1, 1'b1);
    tick();
    set_lane(1, 32'hF1, 1'b1, 1'b1, 1'b1);
    tick();
    set_lane(1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    exp_q = '{33'h0_000000F0, 33'h1_000000F1};
    check_log("t6_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
